// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring division on magnitudes, one quotient bit per cycle,
// followed by a sign-fix cycle and a one-cycle done/write strobe toward the register file.
module div_unit #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      rs1_val,
    input  logic [WIDTH-1:0]      rs2_val,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [WIDTH-1:0]      result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH-1:0]        quot_q;
    logic [WIDTH:0]          rem_q;
    logic [WIDTH-1:0]        divisor_q;
    logic [WIDTH-1:0]        dividend_q;
    logic                    is_rem_q;
    logic                    neg_quot_q;
    logic                    neg_rem_q;
    logic                    div_zero_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]        result_q;
    logic [REG_ADDR_W-1:0]   rd_out_q;
    logic                    done_q;
    logic                    reg_write_q;

    // Operand capture: op[0]=1 selects the unsigned forms, op[1]=1 selects remainder.
    logic                    in_signed;
    logic                    a_neg;
    logic                    b_neg;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;

    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & rs1_val[WIDTH-1];
        b_neg     = in_signed & rs2_val[WIDTH-1];
        a_mag     = a_neg ? (~rs1_val + 1'b1) : rs1_val;
        b_mag     = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    end

    // One restoring step: the top bit of the shifted partial remainder is always 0, so bit WIDTH+1
    // of the difference is a clean borrow.
    logic [WIDTH+1:0]        shifted;
    logic [WIDTH+1:0]        diff;
    logic                    fits;
    logic [WIDTH:0]          rem_d;
    logic [WIDTH-1:0]        quot_d;

    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        diff    = shifted - {2'b00, divisor_q};
        fits    = ~diff[WIDTH+1];
        rem_d   = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
        quot_d  = {quot_q[WIDTH-2:0], fits};
    end

    logic [WIDTH-1:0]        q_fix;
    logic [WIDTH-1:0]        r_fix;
    logic [WIDTH-1:0]        result_d;

    always_comb begin
        q_fix    = div_zero_q ? '1 : (neg_quot_q ? (~quot_q + 1'b1) : quot_q);
        r_fix    = div_zero_q ? dividend_q
                              : (neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0]);
        result_d = is_rem_q ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here is sequential state, so only non-blocking assignments are used;
        // the datapath registers are reset too so a dropped operation leaves no stale result behind.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            is_rem_q    <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            rd_out_q    <= '0;
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_CALC;
                        cnt_q      <= '0;
                        quot_q     <= a_mag;
                        rem_q      <= '0;
                        divisor_q  <= b_mag;
                        dividend_q <= rs1_val;
                        is_rem_q   <= op[1];
                        neg_quot_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (rs2_val == '0);
                        rd_q       <= rd_in;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_CALC: begin
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q     <= S_DONE;
                    result_q    <= result_d;
                    rd_out_q    <= rd_q;
                    done_q      <= 1'b1;
                    reg_write_q <= (rd_q != '0);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = done_q;
    assign reg_write = reg_write_q;
    assign rd_out    = rd_out_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results are queued at issue time and compared when done pulses.
module tb_div_unit;

    localparam int WIDTH   = 32;
    localparam int RW      = 5;
    localparam int LATENCY = 34;
    localparam int BOUND   = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic [RW-1:0]     rd_in;
    logic              busy;
    logic              done;
    logic              reg_write;
    logic [RW-1:0]     rd_out;
    logic [WIDTH-1:0]  result;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [RW-1:0]    rd;
        logic             wr;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_res;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .rd_out    (rd_out),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary");
        $fatal(1);
    end

    // Reference model built from the language's own division operators.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (o[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return o[1] ? r : q;
    endfunction

    // Called at a negedge: presents a request that the next rising edge captures.
    task automatic drive(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [RW-1:0] rd, input logic [WIDTH-1:0] exp_res);
        exp_t e;
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        e.res   = exp_res;
        e.rd    = rd;
        e.wr    = (rd != 0);
        sb.push_back(e);
    endtask

    // Waits for done, checks latency and the scoreboard entry; inject_at>0 fires a stray start mid-flight.
    task automatic collect(input string name, input int inject_at);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (n < BOUND && !seen) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b want 1", name, busy);
                end
            end
            if (inject_at != 0 && n == inject_at) begin
                start   = 1'b1;
                op      = OP_DIVU;
                rs1_val = 32'hFFFF_FFFF;
                rs2_val = 32'd3;
                rd_in   = 5'd31;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: empty queue", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (!seen || n != LATENCY) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want %0d", name, n, seen, LATENCY);
        end
        if (seen) begin
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL %s result: got %h want %h", name, result, e.res);
            end
            checks++;
            if (rd_out !== e.rd || reg_write !== e.wr) begin
                errors++;
                $display("FAIL %s rd/reg_write: got %0d/%b want %0d/%b", name, rd_out, reg_write, e.rd, e.wr);
            end
        end
        last_res = e.res;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        op      = '0;
        rs1_val = '0;
        rs2_val = '0;
        rd_in   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, reg_write} !== 3'b000 || result !== '0 || rd_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b wr=%b res=%h rd=%0d want all zero",
                     busy, done, reg_write, result, rd_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        drive(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
        collect("divu_100_7", 0);
    endtask

    task automatic test_signed();
        drive(OP_DIV, -32'sd7, 32'd2, 5'd1, 32'hFFFF_FFFD);
        collect("div_m7_2", 0);
        drive(OP_REM, -32'sd7, 32'd2, 5'd2, 32'hFFFF_FFFF);
        collect("rem_m7_2", 0);
        drive(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1);
        collect("remu_fff9_2", 0);
        drive(OP_REM, 32'd7, -32'sd2, 5'd4, 32'd1);
        collect("rem_7_m2", 0);
    endtask

    task automatic test_div_zero();
        drive(OP_DIV, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF);
        collect("div_by_zero", 0);
        drive(OP_DIVU, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF);
        collect("divu_by_zero", 0);
        drive(OP_REM, 32'h1234, 32'd0, 5'd8, 32'h1234);
        collect("rem_by_zero", 0);
        drive(OP_REMU, 32'h1234, 32'd0, 5'd9, 32'h1234);
        collect("remu_by_zero", 0);
        drive(OP_DIV, 32'hFFFF_FF00, 32'd0, 5'd10, 32'hFFFF_FFFF);
        collect("div_neg_by_zero", 0);
    endtask

    task automatic test_overflow_x0();
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000);
        collect("div_overflow_x0", 0);
        drive(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);
        collect("rem_overflow", 0);
    endtask

    task automatic test_busy_ignore();
        drive(OP_DIVU, 32'd1000, 32'd10, 5'd12, 32'd100);
        collect("start_during_calc", 5);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stray_start_latched: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_DIVU, 32'd99, 32'd9, 5'd13, 32'd11);
        collect("b2b_first", 0);
        drive(OP_REMU, 32'd99, 32'd10, 5'd14, 32'd9);
        collect("b2b_second", 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got done=%b wr=%b want 0/0", done, reg_write);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== last_res || rd_out !== 5'd14) begin
            errors++;
            $display("FAIL result_hold: got %h/%0d want %h/14", result, rd_out, last_res);
        end
    endtask

    task automatic test_random();
        logic [1:0]       o;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 2 == 0) ? WIDTH'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) b = 32'hFFFF_FFFF;
            drive(o, a, b, RW'($urandom_range(1, 31)), model(o, a, b));
            collect("random", 0);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        drive(OP_DIVU, 32'd5000, 32'd3, 5'd15, 32'd1666);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid_calc: got busy=%b done=%b res=%h want 0/0/0", busy, done, result);
        end
        rst = 1'b0;
        sb.delete();
        pulses = 0;
        repeat (BOUND) begin
            @(negedge clk);
            if (reg_write === 1'b1 || done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_dropped_op: got %0d done/write pulses want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_overflow_x0();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
